// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory, and presents the pc+4 / instruction pair to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        present;
    logic [31:0] present_instr;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        present       = 1'b0;
        present_instr = imem_rdata;

        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_gnt) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        present = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_REQ;
                    end
                end else if (redirect) begin
                    // The granted request is still outstanding; its data must be swallowed.
                    pc_d    = redirect_pc;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    buf_d   = '0;
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    present       = 1'b1;
                    present_instr = buf_q;
                    pc_d          = pc_inc;
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (present) begin
            instr_d    = present_instr;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
        end else if (redirect || !stall) begin
            // Bubble; pc_plus4 keeps its last value.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req     = (state_q == S_REQ);
    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4_q;
    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects, wrap, reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    int n_cmp = 0;
    int n_mis = 0;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [31:0] rpc);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall       = st;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pp4,
                           input logic vld);
        check({tag, ".instr"}, instr_out, ins);
        check({tag, ".pc4"}, pc_plus4_out, pp4);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
        #12;
        chk_out("rst", 32'h13, 32'h0, 1'b0);
        check("rst.pc", pc_out, 32'h0);
        chk_req("rst", 1'b1, 32'h0);
        reset = 1'b0;

        // Sequential fetch with a one-cycle memory
        cyc(1, 0, 0, 0, 0, 0);
        chk_req("seq0w", 1'b0, 0);
        cyc(0, 1, 32'hA0, 0, 0, 0);
        chk_out("seq0", 32'hA0, 32'h4, 1'b1);
        chk_req("seq0", 1'b1, 32'h4);
        cyc(1, 0, 0, 0, 0, 0);
        chk_out("seq1w", 32'h13, 32'h4, 1'b0);
        cyc(0, 1, 32'hA4, 0, 0, 0);
        chk_out("seq1", 32'hA4, 32'h8, 1'b1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hA8, 0, 0, 0);
        chk_out("seq2", 32'hA8, 32'hC, 1'b1);
        chk_req("seq2", 1'b1, 32'hC);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hAC, 0, 0, 0);
        chk_out("seq3", 32'hAC, 32'h10, 1'b1);

        // Stall for three cycles as 0xB0 returns from 0x10
        cyc(1, 0, 0, 0, 0, 0);
        chk_out("stw", 32'h13, 32'h10, 1'b0);
        cyc(0, 1, 32'hB0, 1, 0, 0);
        chk_out("st0", 32'h13, 32'h10, 1'b0);
        chk_req("st0", 1'b0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk_out("st1", 32'h13, 32'h10, 1'b0);
        cyc(0, 1, 32'hEE, 1, 0, 0);
        chk_out("st2", 32'h13, 32'h10, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("strel", 32'hB0, 32'h14, 1'b1);
        chk_req("strel", 1'b1, 32'h14);

        // Redirect while WAIT, stale data arrives two cycles later
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h100);
        chk_out("rw0", 32'h13, 32'h14, 1'b0);
        check("rw0.pc", pc_out, 32'h100);
        chk_req("rw0", 1'b0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("rw1", 32'h13, 32'h14, 1'b0);
        cyc(0, 1, 32'hDEAD, 0, 0, 0);
        chk_out("rw2", 32'h13, 32'h14, 1'b0);
        chk_req("rw2", 1'b1, 32'h100);

        // Redirect coincident with rvalid in WAIT
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hBAD0, 0, 1, 32'h200);
        chk_out("rv", 32'h13, 32'h14, 1'b0);
        chk_req("rv", 1'b1, 32'h200);

        // Redirect in HOLD
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hBAD1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h300);
        chk_out("rh", 32'h13, 32'h14, 1'b0);
        chk_req("rh", 1'b1, 32'h300);

        // Wrap: fetch at 0xFFFF_FFFC
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk_req("wr0", 1'b1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'hC0, 0, 0, 0);
        chk_out("wr", 32'hC0, 32'h0, 1'b1);
        chk_req("wr", 1'b1, 32'h0);

        // Stray rvalid in REQ is ignored
        cyc(0, 1, 32'hEE, 0, 0, 0);
        chk_out("strq", 32'h13, 32'h0, 1'b0);
        chk_req("strq", 1'b1, 32'h0);

        // Asynchronous reset mid-WAIT, late rvalid afterwards
        cyc(0, 0, 0, 0, 1, 32'h40);
        cyc(1, 0, 0, 0, 0, 0);
        check("prerst.pc", pc_out, 32'h40);
        #2;
        reset = 1'b1;
        #1;
        check("arst.pc", pc_out, 32'h0);
        chk_out("arst", 32'h13, 32'h0, 1'b0);
        chk_req("arst", 1'b1, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc(0, 1, 32'h77, 0, 0, 0);
        chk_out("late", 32'h13, 32'h0, 1'b0);
        chk_req("late", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the pc+4 / instruction pair consumed by the IF/ID pipeline register.
- Owns the PC register and issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake.
- Buffers a returned instruction while the hazard unit stalls.
- Squashes in-flight or buffered fetches on a branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction driven on instr_out when no valid instruction is presented.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; combinational, high only in state REQ.
- imem_addr  output  32  fetch address; equals the PC register.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid; at most one per granted request, no earlier than the cycle after gnt.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- stall  input  1  hold request from the hazard unit.
- redirect  input  1  branch/jump taken; flushes the fetch stage.
- redirect_pc  input  32  target PC, sampled with redirect.
- pc_out  output  32  current PC register (debug/trace).
- pc_plus4_out  output  32  registered; PC of the presented instruction + 4, drives the IF/ID pc_in.
- instr_out  output  32  registered; presented instruction, drives the IF/ID instr_in.
- instr_valid  output  1  registered; high when instr_out is a real fetched instruction.

Behaviour:
- Reset (asynchronous): pc=RESET_PC, state=REQ, buffer cleared, pc_plus4_out=0, instr_out=NOP_INSTR, instr_valid=0. Reset mid-transaction abandons any outstanding request; a late rvalid arriving in REQ is ignored.
- Priority: reset > redirect > stall.
- States:
  - REQ: issuing a request.
  - WAIT: request granted, awaiting data.
  - HOLD: data buffered while stalled.
  - DRAIN: discarding the data of a squashed request.
- REQ transitions:
  - imem_req=1, imem_addr=pc.
  - gnt & !redirect -> WAIT.
  - gnt & redirect -> pc<=redirect_pc, DRAIN.
  - !gnt & redirect -> pc<=redirect_pc, stay REQ.
  - Otherwise stay REQ.
- WAIT transitions:
  - rvalid & redirect -> discard data, pc<=redirect_pc, REQ.
  - rvalid & stall -> buffer<=rdata, HOLD.
  - rvalid & !stall -> present rdata, pc<=pc+4, REQ.
  - !rvalid & redirect -> pc<=redirect_pc, DRAIN.
- HOLD transitions:
  - redirect -> drop buffer, pc<=redirect_pc, REQ.
  - !stall -> present buffer, pc<=pc+4, REQ.
  - Otherwise stay HOLD.
- DRAIN transitions:
  - rvalid -> discard data, REQ; pc is already the target.
  - redirect in DRAIN updates pc to the newest redirect_pc, whether or not rvalid arrives in the same cycle.
- Present (on the clock edge): instr_out<=instruction, pc_plus4_out<=pc+4 (pre-increment pc), instr_valid<=1.
- Output registers when not presenting:
  - redirect -> instr_out<=NOP_INSTR, instr_valid<=0 (flush bubble).
  - else stall -> hold all three output registers.
  - else -> instr_out<=NOP_INSTR, instr_valid<=0; pc_plus4_out holds.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. redirect_pc is used unaligned as given, with no alignment checking.
- Throughput: with gnt in the REQ cycle and rvalid one cycle later, one instruction is presented every 2 cycles.
- Protocol violations: rvalid in REQ or HOLD is ignored. Only one request is ever outstanding.

Test Plan:
- Reset: assert reset mid-WAIT -> immediately pc_out=0, instr_valid=0, instr_out=32'h13; after release, imem_req=1 with imem_addr=0.
- Sequential fetch, 1-cycle memory, words 0xA0/0xA4/0xA8 at addresses 0/4/8 -> instr_out sequence 0xA0, 0xA4, 0xA8 with pc_plus4_out 4/8/12, each valid 1 cycle, spaced 2 cycles apart.
- Stall: stall=1 for 3 cycles as rvalid returns 0xB0 at pc=0x10 -> outputs hold their previous values; on release, 0xB0 is presented with pc_plus4_out=0x14 and the next imem_addr=0x14.
- Redirect while WAIT: redirect_pc=0x100, rvalid arrives 2 cycles later carrying 0xDEAD -> 0xDEAD is never presented; the next request has imem_addr=0x100; instr_valid stays 0 throughout.
- Redirect coincident with rvalid in WAIT, and redirect in HOLD -> data dropped, instr_out=32'h13, the next request goes to redirect_pc.
- Wrap: redirect_pc=32'hFFFF_FFFC, returned word 0xC0 -> pc_plus4_out=0, the next imem_addr=0.
